stage_dispatch_sequencer: RTL and testbench

- Control stage directly upstream of the 15-child fan-out hierarchy level; it feeds that level.
- Walks child slots 0..NUM_CHILD-1 in order. For each enabled slot it issues a one-cycle start pulse, then waits for that child's done, bounded by a timeout.
- Reports completion to its own parent with a done pulse and a sticky error flag.
- Allows a parent to bring up or exercise every child instance of one hierarchy level sequentially.

---
 rtl/stage_dispatch_pkg.sv | 33 +++
 rtl/stage_dispatch_timer.sv | 45 ++++
 rtl/stage_dispatch_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_stage_dispatch_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stage_dispatch_pkg.sv
// -----------------------------------------------------------------------------
// stage_dispatch_pkg
//
// Shared definitions for the stage dispatch sequencer:
//   - state_t       : sequencer FSM state encoding
//   - NUM_CHILD_DEF : default number of child slots driven by one sequencer
//   - TIMEOUT_DEF   : default number of WAIT cycles before a slot times out
//   - idx_width()   : width of a slot index for a given slot count (min 1 bit)
// -----------------------------------------------------------------------------
package stage_dispatch_pkg;

  localparam int NUM_CHILD_DEF = 15;
  localparam int TIMEOUT_DEF   = 200;

  // IDLE   : waiting for a start request
  // LAUNCH : pulse the current slot's start (if enabled)
  // WAIT   : wait for the current slot's done, bounded by the timer
  // NEXT   : advance to the following slot or finish
  // FINISH : one-cycle completion pulse towards the parent
  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    NEXT,
    FINISH
  } state_t;

  // A single slot still needs a one-bit index so that port widths stay legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stage_dispatch_timer.sv
// -----------------------------------------------------------------------------
// stage_dispatch_timer
//
// Saturating timeout counter for one WAIT phase of the sequencer.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset (counter -> 0)
//   clear    in   restart the count from 0 (has priority over enable)
//   enable   in   count up by one this cycle
//   expired  out  counter has reached TIMEOUT-1
//
// The counter never wraps: once it reaches TIMEOUT-1 it holds there until
// cleared, so a stalled enable cannot alias back to an early count.
// -----------------------------------------------------------------------------
module stage_dispatch_timer
  import stage_dispatch_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TMR_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TMR_W-1:0] LAST_COUNT = TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] count_reg;

  assign expired = (count_reg == LAST_COUNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !expired) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/stage_dispatch_sequencer.sv
// -----------------------------------------------------------------------------
// stage_dispatch_sequencer
//
// Walks child slots 0..NUM_CHILD-1 in order. Each enabled slot receives a
// one-cycle start pulse and is then waited on until its done bit is seen or
// the timeout expires. Masked slots are skipped. A done pulse and a sticky
// error flag report the outcome to the parent.
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   synchronous active-high reset
//   start_i        in   request to run one sequence
//   start_ready_o  out  request can be accepted (only in IDLE)
//   child_mask_i   in   per-slot enable, latched when a request is accepted
//   child_start_o  out  one-hot, one-cycle start pulse to the current slot
//   child_done_i   in   per-slot completion; only the current slot is looked at
//   busy_o         out  sequence in progress (any state but IDLE)
//   cur_idx_o      out  slot currently being processed
//   done_o         out  one-cycle pulse when the sequence ends
//   err_o          out  at least one slot timed out in the last sequence
//   err_idx_o      out  index of the first slot that timed out
//
// Slot costs: answered-in-first-WAIT-cycle slot = 3 cycles, masked slot =
// 2 cycles, timed-out slot = TIMEOUT+2 cycles. The FINISH cycle follows the
// last slot's NEXT cycle and cannot accept a new request, so a start held
// high is taken in the IDLE cycle after FINISH.
// -----------------------------------------------------------------------------
module stage_dispatch_sequencer
  import stage_dispatch_pkg::*;
#(
  parameter int NUM_CHILD = NUM_CHILD_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF,
  parameter int TMR_W     = 8,
  parameter int IDX_W     = idx_width(NUM_CHILD)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  output logic                 start_ready_o,
  input  logic [NUM_CHILD-1:0] child_mask_i,
  output logic [NUM_CHILD-1:0] child_start_o,
  input  logic [NUM_CHILD-1:0] child_done_i,
  output logic                 busy_o,
  output logic [IDX_W-1:0]     cur_idx_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [IDX_W-1:0]     err_idx_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHILD - 1);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t               state_reg,   state_next;
  logic [IDX_W-1:0]     idx_reg,     idx_next;
  logic [NUM_CHILD-1:0] mask_reg,    mask_next;
  logic                 err_reg,     err_next;
  logic [IDX_W-1:0]     err_idx_reg, err_idx_next;

  // Control strobes decoded by the FSM
  logic tmr_clear;
  logic tmr_enable;
  logic tmr_expired;
  logic launch_fire;

  // Only the current slot's done bit is ever observed.
  logic done_cur;
  assign done_cur = child_done_i[idx_reg];

  // ---------------------------------------------------------------------------
  // Timeout counter
  // ---------------------------------------------------------------------------
  stage_dispatch_timer #(
    .TIMEOUT (TIMEOUT),
    .TMR_W   (TMR_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clear),
    .enable  (tmr_enable),
    .expired (tmr_expired)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      mask_reg    <= '0;
      err_reg     <= 1'b0;
      err_idx_reg <= '0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      mask_reg    <= mask_next;
      err_reg     <= err_next;
      err_idx_reg <= err_idx_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and control strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    mask_next    = mask_reg;
    err_next     = err_reg;
    err_idx_next = err_idx_reg;
    tmr_clear    = 1'b0;
    tmr_enable   = 1'b0;
    launch_fire  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start_i) begin
          mask_next    = child_mask_i;
          idx_next     = '0;
          err_next     = 1'b0;
          err_idx_next = '0;
          state_next   = LAUNCH;
        end
      end

      LAUNCH: begin
        // The timer is restarted for every slot; harmless for masked slots.
        tmr_clear = 1'b1;
        if (mask_reg[idx_reg]) begin
          launch_fire = 1'b1;
          state_next  = WAIT;
        end else begin
          state_next  = NEXT;
        end
      end

      WAIT: begin
        if (done_cur) begin
          state_next = NEXT;
        end else begin
          tmr_enable = 1'b1;
          if (tmr_expired) begin
            err_next = 1'b1;
            // Keep the first offender only.
            if (!err_reg) begin
              err_idx_next = idx_reg;
            end
            state_next = NEXT;
          end
        end
      end

      NEXT: begin
        if (idx_reg == LAST_IDX) begin
          state_next = FINISH;
        end else begin
          idx_next   = idx_reg + 1'b1;
          state_next = LAUNCH;
        end
      end

      FINISH: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign start_ready_o = (state_reg == IDLE);
  assign busy_o        = (state_reg != IDLE);
  assign done_o        = (state_reg == FINISH);
  assign cur_idx_o     = idx_reg;
  assign err_o         = err_reg;
  assign err_idx_o     = err_idx_reg;

  // One-hot start decode: only the slot matching the current index can fire.
  generate
    for (genvar gi = 0; gi < NUM_CHILD; gi++) begin : g_start
      assign child_start_o[gi] = launch_fire && (idx_reg == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: tb/tb_stage_dispatch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_stage_dispatch_sequencer
//
// Self-checking bench. For each sequence a reference schedule is computed
// from slot costs (enabled slot answering after L cycles costs L+2, masked
// slot costs 2, timed-out slot costs TIMEOUT+2). Every cycle of the
// sequence the observed outputs are compared to the expected ones.
// Children are emulated from that schedule: slot i drives done L_i cycles
// after its launch cycle; other done bits carry random noise except on the
// slot currently being waited on.
// -----------------------------------------------------------------------------
module tb_stage_dispatch_sequencer;

  localparam int NC   = 15;
  localparam int TO   = 200;
  localparam int TW   = 8;
  localparam int IW   = 4;
  localparam int NEVER = 0;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic          start_ready_o;
  logic [NC-1:0] child_mask_i;
  logic [NC-1:0] child_start_o;
  logic [NC-1:0] child_done_i;
  logic          busy_o;
  logic [IW-1:0] cur_idx_o;
  logic          done_o;
  logic          err_o;
  logic [IW-1:0] err_idx_o;

  always #5 clk = ~clk;

  stage_dispatch_sequencer #(
    .NUM_CHILD (NC),
    .TIMEOUT   (TO),
    .TMR_W     (TW),
    .IDX_W     (IW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .start_ready_o (start_ready_o),
    .child_mask_i  (child_mask_i),
    .child_start_o (child_start_o),
    .child_done_i  (child_done_i),
    .busy_o        (busy_o),
    .cur_idx_o     (cur_idx_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .err_idx_o     (err_idx_o)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Packed view: {ready, busy, done, err, err_idx, idx, child_start}
  function automatic logic [63:0] pk(input logic rdy, input logic bsy, input logic dn,
                                     input logic er, input logic [IW-1:0] eidx,
                                     input logic [IW-1:0] idx, input logic [NC-1:0] st);
    return {37'd0, rdy, bsy, dn, er, eidx, idx, st};
  endfunction

  function automatic logic [63:0] obs_vec();
    return pk(start_ready_o, busy_o, done_o, err_o, err_idx_o, cur_idx_o, child_start_o);
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: slot schedule of one sequence
  // ---------------------------------------------------------------------------
  int            lat [NC];      // done latency after launch, NEVER = no answer
  int            seg_start [NC];
  int            cost [NC];
  logic [NC-1:0] mdl_mask;
  int            n_done;
  int            first_err;
  int            err_cycle;
  int            noise_mode;    // 0 none, 1 random, 2 bit 5 held while slot 2 active
  bit            hold;
  int            seq_no = 0;

  function automatic void build_model();
    int c;
    c = 1;
    first_err = -1;
    for (int i = 0; i < NC; i++) begin
      seg_start[i] = c;
      if (mdl_mask[i]) begin
        if (lat[i] >= 1 && lat[i] <= TO) begin
          cost[i] = lat[i] + 2;
        end else begin
          cost[i] = TO + 2;
          if (first_err < 0) first_err = i;
        end
      end else begin
        cost[i] = 2;
      end
      c += cost[i];
    end
    n_done    = c;
    err_cycle = (first_err >= 0) ? seg_start[first_err] + cost[first_err] - 1 : 1 << 30;
  endfunction

  function automatic int slot_of(input int c);
    int s;
    s = NC - 1;
    for (int i = 0; i < NC; i++) begin
      if (c >= seg_start[i] && c < seg_start[i] + cost[i]) s = i;
    end
    return s;
  endfunction

  function automatic bit in_wait(input int c);
    int s;
    s = slot_of(c);
    return (c < n_done) && mdl_mask[s] && (c > seg_start[s]) &&
           (c < seg_start[s] + cost[s] - 1);
  endfunction

  function automatic logic [63:0] exp_vec(input int c);
    int            s;
    logic [NC-1:0] st;
    logic          er;
    s  = slot_of(c);
    st = '0;
    if (c < n_done && mdl_mask[s] && c == seg_start[s]) st[s] = 1'b1;
    er = (c >= err_cycle);
    return pk(1'b0, 1'b1, (c == n_done), er, er ? IW'(first_err) : '0, IW'(s), st);
  endfunction

  function automatic logic [NC-1:0] drive_done(input int c);
    logic [NC-1:0] d;
    logic [NC-1:0] nz;
    d  = '0;
    nz = '0;
    for (int i = 0; i < NC; i++) begin
      if (mdl_mask[i] && lat[i] != NEVER && c == seg_start[i] + lat[i]) d[i] = 1'b1;
    end
    if (noise_mode == 1) begin
      nz = NC'($urandom);
      if (in_wait(c)) nz[slot_of(c)] = 1'b0;
    end else if (noise_mode == 2) begin
      if (slot_of(c) == 2 && c < n_done) nz[5] = 1'b1;
    end
    return d | nz;
  endfunction

  // ---------------------------------------------------------------------------
  // One sequence. Entered and left at a falling edge in an IDLE cycle.
  // abort_at > 0 asserts reset in that cycle of the sequence.
  // ---------------------------------------------------------------------------
  task automatic run_seq(input logic [NC-1:0] m, input int abort_at);
    seq_no++;
    mdl_mask = m;
    build_model();
    child_mask_i = m;
    start_i      = 1'b1;
    for (int c = 1; c <= n_done; c++) begin
      @(posedge clk);
      #1;
      start_i      = hold ? 1'b1 : 1'($urandom_range(0, 1));
      child_mask_i = NC'($urandom);
      child_done_i = drive_done(c);
      @(negedge clk);
      check_eq($sformatf("seq%0d_cyc%0d", seq_no, c), obs_vec(), exp_vec(c));
      if (c == abort_at) begin
        rst          = 1'b1;
        start_i      = 1'b0;
        child_done_i = '0;
        for (int k = 0; k < 3; k++) begin
          @(posedge clk);
          #1;
          rst = 1'b0;
          @(negedge clk);
          check_eq($sformatf("seq%0d_abort%0d", seq_no, k), obs_vec(),
                   pk(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0));
        end
        $display("seq %0d mask=%h aborted at cycle %0d", seq_no, m, abort_at);
        return;
      end
    end
    @(posedge clk);
    #1;
    child_done_i = '0;
    @(negedge clk);
    check_eq($sformatf("seq%0d_idle", seq_no), obs_vec(),
             pk(1'b1, 1'b0, 1'b0, (first_err >= 0),
                (first_err >= 0) ? IW'(first_err) : '0, IW'(NC - 1), '0));
    $display("seq %0d mask=%h done_cycle=%0d first_err=%0d", seq_no, m, n_done, first_err);
  endtask

  task automatic set_lat(input int v);
    for (int i = 0; i < NC; i++) lat[i] = v;
  endtask

  task automatic rand_lat();
    for (int i = 0; i < NC; i++) begin
      case ($urandom_range(0, 31))
        0:       lat[i] = NEVER;
        1:       lat[i] = TO;
        2:       lat[i] = TO + 1;
        3:       lat[i] = TO - 1;
        default: lat[i] = $urandom_range(1, 6);
      endcase
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst          = 1'b1;
    start_i      = 1'b1;       // must be ignored during reset
    child_mask_i = '1;
    child_done_i = '0;
    hold         = 1'b0;
    noise_mode   = 0;
    set_lat(1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset", obs_vec(), pk(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0));
    rst     = 1'b0;
    start_i = 1'b0;
    @(negedge clk);
    check_eq("post_reset", obs_vec(), pk(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0));

    // All slots enabled, every child answers one cycle after its start.
    set_lat(1);
    run_seq(15'h7FFF, -1);

    // All slots masked.
    run_seq(15'h0000, -1);

    // Slots 3 and 9 never answer.
    set_lat(1);
    lat[3] = NEVER;
    lat[9] = NEVER;
    run_seq(15'h7FFF, -1);

    // Foreign done bit held high while slot 2 is waiting.
    set_lat(1);
    lat[2]     = 6;
    noise_mode = 2;
    run_seq(15'h7FFF, -1);
    noise_mode = 0;

    // Reset while waiting on slot 7, with an error already recorded.
    set_lat(1);
    lat[2] = NEVER;
    lat[7] = NEVER;
    run_seq(15'h7FFF, 230);
    set_lat(1);
    run_seq(15'h7FFF, -1);

    // Start held high across back-to-back sequences.
    hold = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NC; i++) lat[i] = $urandom_range(1, 4);
      run_seq(NC'($urandom), -1);
    end
    hold = 1'b0;

    // Randomized sequences with noise on foreign done bits.
    noise_mode = 1;
    for (int r = 0; r < 20; r++) begin
      rand_lat();
      hold = 1'($urandom_range(0, 1));
      run_seq(NC'($urandom), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
